// File: rtl/board_controller.sv
// board_controller: live Sudoku grid, cursor and lock mask with entry handshake, clear and one-deep undo
module board_controller #(
  parameter int BOX = 3,
  parameter int DW = 4,
  parameter int CW = 8,
  parameter int OPS_MAX = 9999,
  parameter int HOME = BOX * BOX * BOX * BOX / 2,
  localparam int SIDE = BOX * BOX,
  localparam int CELLS = SIDE * SIDE
) (
  input  logic                CLK_100MHz,
  input  logic                RST_n,
  input  logic                UP,
  input  logic                DOWN,
  input  logic                LEFT,
  input  logic                RIGHT,
  input  logic                CENTER,
  input  logic                UNDO,
  input  logic                win_tag,
  input  logic                lose_tag,
  input  logic                init_tag,
  input  logic [CELLS*DW-1:0] temp_map,
  input  logic [CELLS-1:0]    temp_mask,
  input  logic                num_valid,
  input  logic [DW-1:0]       num_code,
  output logic                num_ready,
  output logic [CELLS*DW-1:0] cur_map,
  output logic [CW-1:0]       cur_select,
  output logic [CELLS-1:0]    read_only,
  output logic                inited,
  output logic [15:0]         op_counter,
  output logic                write_reject
);
  typedef enum logic [1:0] {UNINIT, LOAD, PLAY, FROZEN} state_t;
  localparam logic [CW-1:0] SIDE_C = CW'(SIDE);
  localparam logic [CW-1:0] LAST_ROW = CW'(CELLS - SIDE);
  localparam logic [CW-1:0] HOME_C = CW'(HOME);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [DW-1:0] MAX_CODE = DW'(SIDE);
  localparam logic [15:0] OPS_C = 16'(OPS_MAX);
  localparam logic [CELLS*DW-1:0] CELL_ONES = {{(CELLS*DW-DW){1'b0}}, {DW{1'b1}}};
  state_t st_q, st_d;
  logic [CELLS*DW-1:0] map_q, load_map;
  logic [CELLS-1:0] ro_q;
  logic [CW-1:0] sel_q, undo_idx_q, up_sel, down_sel, left_sel, right_sel, col;
  logic [DW-1:0] undo_val_q, cur_val;
  logic [15:0] ops_q;
  logic rej_q, ready_q, inited_q, undo_v_q, locked, bad_code;
  function automatic logic [CELLS*DW-1:0] put(input logic [CELLS*DW-1:0] m, input logic [CW-1:0] idx,
                                              input logic [DW-1:0] v);
    put = (m & ~(CELL_ONES << (32'(idx) * DW))) | ({{(CELLS*DW-DW){1'b0}}, v} << (32'(idx) * DW));
  endfunction
  // Cell under cursor, lock test, wrapped neighbours, masked puzzle image and next state
  always_comb begin
    load_map = '0;
    for (int i = 0; i < CELLS; i++) load_map[i*DW +: DW] = temp_mask[i] ? temp_map[i*DW +: DW] : '0;
    cur_val = DW'(map_q >> (32'(sel_q) * DW));
    locked = |(ro_q & (CELLS'(1) << sel_q));
    bad_code = num_code > MAX_CODE;
    col = sel_q % SIDE_C;
    up_sel = sel_q < SIDE_C ? sel_q + LAST_ROW : sel_q - SIDE_C;
    down_sel = sel_q >= LAST_ROW ? sel_q - LAST_ROW : sel_q + SIDE_C;
    left_sel = col == '0 ? sel_q + SIDE_C - ONE : sel_q - ONE;
    right_sel = col == SIDE_C - ONE ? sel_q - SIDE_C + ONE : sel_q + ONE;
    st_d = st_q != UNINIT && !init_tag ? UNINIT :
           st_q == UNINIT && init_tag ? LOAD :
           st_q == LOAD ? PLAY :
           st_q == PLAY && (win_tag || lose_tag) ? FROZEN :
           st_q == FROZEN && !win_tag && !lose_tag ? PLAY : st_q;
  end
  // Game FSM: load the puzzle, then apply at most one action per cycle in priority order
  always_ff @(posedge CLK_100MHz) begin
    if (!RST_n) begin
      st_q <= UNINIT;
      map_q <= '0;
      ro_q <= '0;
      sel_q <= '0;
      ops_q <= '0;
      rej_q <= 1'b0;
      ready_q <= 1'b0;
      inited_q <= 1'b0;
      undo_v_q <= 1'b0;
      undo_idx_q <= '0;
      undo_val_q <= '0;
    end else begin
      st_q <= st_d;
      ready_q <= st_d == PLAY;
      inited_q <= st_d == PLAY || st_d == FROZEN;
      rej_q <= 1'b0;
      if (st_q == LOAD) begin
        map_q <= load_map;
        ro_q <= temp_mask;
        sel_q <= HOME_C;
        ops_q <= '0;
        undo_v_q <= 1'b0;
      end else if (st_q == PLAY) begin
        if (num_valid) begin
          if (locked || bad_code) rej_q <= 1'b1;
          else begin
            map_q <= put(map_q, sel_q, num_code);
            undo_v_q <= 1'b1;
            undo_idx_q <= sel_q;
            undo_val_q <= cur_val;
            ops_q <= ops_q == OPS_C ? '0 : ops_q + 16'd1;
          end
        end else if (CENTER) begin
          if (!locked) begin
            map_q <= put(map_q, sel_q, '0);
            undo_v_q <= 1'b1;
            undo_idx_q <= sel_q;
            undo_val_q <= cur_val;
          end
        end else if (UNDO) begin
          if (undo_v_q) begin
            map_q <= put(map_q, undo_idx_q, undo_val_q);
            undo_v_q <= 1'b0;
          end
        end else if (UP) sel_q <= up_sel;
        else if (DOWN) sel_q <= down_sel;
        else if (LEFT) sel_q <= left_sel;
        else if (RIGHT) sel_q <= right_sel;
      end
    end
  end
  assign num_ready = ready_q;
  assign cur_map = map_q;
  assign cur_select = sel_q;
  assign read_only = ro_q;
  assign inited = inited_q;
  assign op_counter = ops_q;
  assign write_reject = rej_q;
endmodule

// File: tb/tb_board_controller.sv
// tb_board_controller: scoreboard bench for the 9x9 controller plus a 4x4 build for wrap checks
module tb_board_controller;
  localparam logic [6:0] E = 7'b1000000, C = 7'b0100000, U = 7'b0010000, UA = 7'b0001000,
                         DN = 7'b0000100, L = 7'b0000010, R = 7'b0000001;
  localparam int NP = 37;
  localparam int NB = 11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic up = 0, down = 0, lf = 0, rt = 0, center = 0, undo = 0, win = 0, lose = 0, init = 0, nv = 0;
  logic [323:0] tmap;
  logic [80:0] tmask;
  logic [3:0] code = '0;
  logic [323:0] cur_map;
  logic [7:0] sel;
  logic [80:0] ro;
  logic inited, rej, ready;
  logic [15:0] ops;
  logic [47:0] tmap2 = '0;
  logic [15:0] tmask2 = '0;
  logic [2:0] code2;
  logic [47:0] cur_map2;
  logic [3:0] sel2;
  logic [15:0] ro2;
  logic inited2, rej2, ready2;
  logic [15:0] ops2;
  int errors = 0;
  int checks = 0;
  typedef struct {int sel; int op; int rej; logic [323:0] map;} exp_t;
  exp_t sb[$];
  int sb2[$];
  int m_map[81];
  bit m_ro[81];
  int m_sel, m_ops, m_ui, m_uval;
  bit m_uv;
  logic [6:0] pa [0:NP-1] = '{E, 7'd0, R, E, E, E, E, E, U, U, C, U, E, U, L, C, E|C|R, R, E|C|R,
                              C|U, U|UA, UA|DN, DN|L, L|R, UA, UA, UA, UA, L, L, L, L, UA, L, R, DN, R};
  int pc [0:NP-1] = '{5, 0, 0, 5, 10, 9, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [6:0] ba [0:NB-1] = '{UA, UA, UA, L, R, DN, DN, R, R, R, R};
  assign code2 = code[2:0];
  always #5 clk = ~clk;
  board_controller dut (
    .CLK_100MHz(clk), .RST_n(rst_n), .UP(up), .DOWN(down), .LEFT(lf), .RIGHT(rt), .CENTER(center),
    .UNDO(undo), .win_tag(win), .lose_tag(lose), .init_tag(init), .temp_map(tmap), .temp_mask(tmask),
    .num_valid(nv), .num_code(code), .num_ready(ready), .cur_map(cur_map), .cur_select(sel),
    .read_only(ro), .inited(inited), .op_counter(ops), .write_reject(rej)
  );
  board_controller #(.BOX(2), .DW(3), .CW(4)) dut2 (
    .CLK_100MHz(clk), .RST_n(rst_n), .UP(up), .DOWN(down), .LEFT(lf), .RIGHT(rt), .CENTER(center),
    .UNDO(undo), .win_tag(win), .lose_tag(lose), .init_tag(init), .temp_map(tmap2), .temp_mask(tmask2),
    .num_valid(nv), .num_code(code2), .num_ready(ready2), .cur_map(cur_map2), .cur_select(sel2),
    .read_only(ro2), .inited(inited2), .op_counter(ops2), .write_reject(rej2)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [6:0] a, input int c);
    {nv, center, undo, up, down, lf, rt} = a;
    code = 4'(c);
  endtask
  function automatic logic [323:0] model_vec();
    logic [323:0] v = '0;
    for (int i = 0; i < 81; i++) v[i*4 +: 4] = 4'(m_map[i]);
    return v;
  endfunction
  function automatic void model_load();
    for (int i = 0; i < 81; i++) begin
      m_ro[i] = tmask[i];
      m_map[i] = tmask[i] ? int'(tmap[i*4 +: 4]) : 0;
    end
    m_sel = 40;
    m_ops = 0;
    m_uv = 0;
  endfunction
  function automatic bit model_apply(input logic [6:0] a, input int c);
    int r = m_sel / 9;
    int k = m_sel % 9;
    if (a[6]) begin
      if (m_ro[m_sel] || c > 9) return 1'b1;
      m_uv = 1;
      m_ui = m_sel;
      m_uval = m_map[m_sel];
      m_map[m_sel] = c;
      m_ops = m_ops == 9999 ? 0 : m_ops + 1;
    end else if (a[5]) begin
      if (!m_ro[m_sel]) begin
        m_uv = 1;
        m_ui = m_sel;
        m_uval = m_map[m_sel];
        m_map[m_sel] = 0;
      end
    end else if (a[4]) begin
      if (m_uv) begin
        m_map[m_ui] = m_uval;
        m_uv = 0;
      end
    end else if (a[3]) m_sel = ((r + 8) % 9) * 9 + k;
    else if (a[2]) m_sel = ((r + 1) % 9) * 9 + k;
    else if (a[1]) m_sel = r * 9 + (k + 8) % 9;
    else if (a[0]) m_sel = r * 9 + (k + 1) % 9;
    return 1'b0;
  endfunction
  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    checks++; if (cur_map !== '0) begin errors++; $display("FAIL reset_map got %h want 0", cur_map); end
    checks++; if (ro !== '0) begin errors++; $display("FAIL reset_ro got %h want 0", ro); end
    checks++; if ({sel, inited, ready, rej} !== '0) begin errors++;
      $display("FAIL reset_ctl got sel=%0d inited=%b ready=%b rej=%b want zeros", sel, inited, ready, rej); end
    checks++; if (ops !== 16'd0) begin errors++; $display("FAIL reset_ops got %0d want 0", ops); end
    rst_n = 1;
  endtask
  task automatic test_load();
    init = 1;
    tick();
    checks++; if (inited !== 1'b0 || ready !== 1'b0) begin errors++;
      $display("FAIL load_cycle got inited=%b ready=%b want 0 0", inited, ready); end
    tick();
    model_load();
    checks++; if (cur_map !== model_vec()) begin errors++; $display("FAIL load_map got %h want %h", cur_map, model_vec()); end
    checks++; if (ro !== tmask) begin errors++; $display("FAIL load_ro got %h want %h", ro, tmask); end
    checks++; if (sel !== 8'd40) begin errors++; $display("FAIL load_sel got %0d want 40", sel); end
    checks++; if (inited !== 1'b1 || ready !== 1'b1) begin errors++;
      $display("FAIL load_flags got inited=%b ready=%b want 1 1", inited, ready); end
  endtask
  task automatic test_play();
    exp_t x;
    for (int s = 0; s < NP; s++) begin
      drive(pa[s], pc[s]);
      x.rej = int'(model_apply(pa[s], pc[s]));
      x.sel = m_sel;
      x.op = m_ops;
      x.map = model_vec();
      sb.push_back(x);
      tick();
      drive('0, 0);
      x = sb.pop_front();
      checks++; if (sel !== 8'(x.sel)) begin errors++; $display("FAIL play%0d_sel got %0d want %0d", s, sel, x.sel); end
      checks++; if (ops !== 16'(x.op)) begin errors++; $display("FAIL play%0d_ops got %0d want %0d", s, ops, x.op); end
      checks++; if (rej !== 1'(x.rej)) begin errors++; $display("FAIL play%0d_rej got %b want %0d", s, rej, x.rej); end
      checks++; if (cur_map !== x.map) begin errors++; $display("FAIL play%0d_map got %h want %h", s, cur_map, x.map); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL play%0d_ready got %b want 1", s, ready); end
    end
  endtask
  task automatic test_op_wrap();
    exp_t x;
    int n = 9999 - m_ops;
    bit r;
    for (int i = 0; i < n; i++) r = model_apply(E, 1);
    x.op = m_ops;
    x.map = model_vec();
    sb.push_back(x);
    drive(E, 1);
    repeat (n) @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++; if (ops !== 16'(x.op)) begin errors++; $display("FAIL opwrap_max got %0d want %0d", ops, x.op); end
    checks++; if (cur_map !== x.map || rej !== 1'b0) begin errors++;
      $display("FAIL opwrap_map got %h rej=%b want %h rej=0", cur_map, rej, x.map); end
    r = model_apply(E, 1);
    x.op = m_ops;
    sb.push_back(x);
    tick();
    drive('0, 0);
    x = sb.pop_front();
    checks++; if (ops !== 16'(x.op)) begin errors++; $display("FAIL opwrap_zero got %0d want %0d", ops, x.op); end
  endtask
  task automatic test_freeze();
    bit r;
    lose = 1;
    drive(E, 4);
    r = model_apply(E, 4);
    tick();
    checks++; if (cur_map !== model_vec() || ops !== 16'(m_ops)) begin errors++;
      $display("FAIL freeze_edge got ops=%0d map=%h want ops=%0d map=%h", ops, cur_map, m_ops, model_vec()); end
    checks++; if (ready !== 1'b0 || inited !== 1'b1) begin errors++;
      $display("FAIL freeze_flags got ready=%b inited=%b want 0 1", ready, inited); end
    drive(E | R, 5);
    tick();
    checks++; if (cur_map !== model_vec() || sel !== 8'(m_sel) || ops !== 16'(m_ops) || rej !== 1'b0) begin errors++;
      $display("FAIL freeze_ignore got sel=%0d ops=%0d rej=%b want sel=%0d ops=%0d rej=0", sel, ops, rej, m_sel, m_ops); end
    drive('0, 0);
    lose = 0;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL unfreeze_ready got %b want 1", ready); end
    win = 1;
    drive(R, 0);
    r = model_apply(R, 0);
    tick();
    checks++; if (sel !== 8'(m_sel) || ready !== 1'b0) begin errors++;
      $display("FAIL win_edge got sel=%0d ready=%b want sel=%0d ready=0", sel, ready, m_sel); end
    drive('0, 0);
    win = 0;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL unwin_ready got %b want 1", ready); end
  endtask
  task automatic test_init_drop();
    bit r;
    init = 0;
    tick();
    checks++; if (inited !== 1'b0 || ready !== 1'b0) begin errors++;
      $display("FAIL drop_flags got inited=%b ready=%b want 0 0", inited, ready); end
    checks++; if (cur_map !== model_vec() || ops !== 16'(m_ops)) begin errors++;
      $display("FAIL drop_retain got ops=%0d map=%h want ops=%0d map=%h", ops, cur_map, m_ops, model_vec()); end
    drive(R, 0);
    tick();
    drive('0, 0);
    checks++; if (sel !== 8'(m_sel)) begin errors++; $display("FAIL drop_move got %0d want %0d", sel, m_sel); end
    init = 1;
    tick();
    tick();
    model_load();
    checks++; if (cur_map !== model_vec() || sel !== 8'd40 || ops !== 16'd0) begin errors++;
      $display("FAIL reload got sel=%0d ops=%0d map=%h want sel=40 ops=0 map=%h", sel, ops, cur_map, model_vec()); end
    drive(U, 0);
    r = model_apply(U, 0);
    tick();
    drive('0, 0);
    checks++; if (cur_map !== model_vec()) begin errors++; $display("FAIL reload_undo got %h want %h", cur_map, model_vec()); end
  endtask
  task automatic test_reset_mid();
    drive(E | R, 3);
    rst_n = 0;
    tick();
    drive('0, 0);
    checks++; if (cur_map !== '0 || ro !== '0 || {sel, inited, ready, rej} !== '0 || ops !== 16'd0) begin errors++;
      $display("FAIL rst_game got sel=%0d ops=%0d inited=%b ready=%b rej=%b want zeros", sel, ops, inited, ready, rej); end
    rst_n = 1;
    tick();
    rst_n = 0;
    tick();
    checks++; if (cur_map !== '0 || ro !== '0 || inited !== 1'b0 || sel !== 8'd0) begin errors++;
      $display("FAIL rst_load got sel=%0d inited=%b map=%h want 0 0 0", sel, inited, cur_map); end
    rst_n = 1;
    init = 0;
    tick();
  endtask
  task automatic test_box2();
    int s2;
    int e;
    rst_n = 0;
    tick();
    rst_n = 1;
    init = 1;
    tick();
    tick();
    checks++; if (sel2 !== 4'd8 || ready2 !== 1'b1 || inited2 !== 1'b1) begin errors++;
      $display("FAIL box2_load got sel=%0d ready=%b inited=%b want 8 1 1", sel2, ready2, inited2); end
    s2 = 8;
    for (int s = 0; s < NB; s++) begin
      s2 = ba[s][3] ? ((s2 / 4 + 3) % 4) * 4 + s2 % 4 :
           ba[s][2] ? ((s2 / 4 + 1) % 4) * 4 + s2 % 4 :
           ba[s][1] ? (s2 / 4) * 4 + (s2 % 4 + 3) % 4 : (s2 / 4) * 4 + (s2 % 4 + 1) % 4;
      sb2.push_back(s2);
      drive(ba[s], 0);
      tick();
      drive('0, 0);
      e = sb2.pop_front();
      checks++; if (sel2 !== 4'(e)) begin errors++; $display("FAIL box2_move%0d got %0d want %0d", s, sel2, e); end
    end
  endtask
  initial begin
    for (int i = 0; i < 81; i++) tmap[i*4 +: 4] = 4'd9;
    tmap[160 +: 4] = 4'd7;
    tmask = '0;
    tmask[40] = 1'b1;
    test_reset();
    test_load();
    test_play();
    test_op_wrap();
    test_freeze();
    test_init_drop();
    test_reset_mid();
    test_box2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/board_controller.md
# board_controller

Parametrised Sudoku board state controller: holds the live grid, the cursor and the locked-cell mask, and applies moves, number entries, clears and a one-deep undo. It sits between the puzzle generator (`temp_map`/`temp_mask`) and the input decoders upstream, and the renderer and win/lose checker downstream. It generalises the fixed 9x9 board controller to any box size, and replaces its ad-hoc read/clear flags with a valid/ready entry handshake, explicit states, reject reporting and undo.

## Interface
- `BOX`, 3, box edge; `SIDE = BOX*BOX` and `CELLS = SIDE*SIDE` are derived localparams (`BOX` = 2..3).
- `DW`, 4, bits per cell; `2**DW > SIDE` is required.
- `CW`, 8, cursor width; `2**CW >= CELLS` is required.
- `OPS_MAX`, 9999, last `op_counter` value before it wraps to 0.
- `HOME`, `CELLS/2`, cursor position after load (40 for `BOX`=3).

Ports:
- `CLK_100MHz`  in  1  system clock; all logic is on its rising edge.
- `RST_n`  in  1  synchronous, active-low reset.
- `UP`, `DOWN`, `LEFT`, `RIGHT`, `CENTER`, `UNDO`  in  1 each  one-cycle pulses, debounced upstream.
- `win_tag`, `lose_tag`  in  1 each  game-over levels.
- `init_tag`  in  1  level; puzzle on `temp_map`/`temp_mask` is valid.
- `temp_map`  in  `CELLS*DW`  solution; cell i is at `[i*DW +: DW]`.
- `temp_mask`  in  `CELLS`  1 = given (locked) cell.
- `num_valid`  in  1  entry request.
- `num_code`  in  `DW`  entry value; 0 = erase.
- `num_ready`  out  1  entry accept.
- `cur_map`  out  `CELLS*DW`  live grid.
- `cur_select`  out  `CW`  cursor index (row-major).
- `read_only`  out  `CELLS`  latched lock mask.
- `inited`  out  1  high in PLAY or FROZEN.
- `op_counter`  out  16  accepted-entry count.
- `write_reject`  out  1  one-cycle pulse when an entry is refused.

## Operation
States:
- UNINIT (reset state).
- LOAD (1 cycle).
- PLAY.
- FROZEN.

Transitions:
- UNINIT -> LOAD when `init_tag`=1.
- LOAD -> PLAY unconditionally.
- PLAY -> FROZEN when `win_tag|lose_tag`.
- FROZEN -> PLAY when both tags are 0.
- Any non-UNINIT state -> UNINIT when `init_tag`=0. The grid is retained.

LOAD:
- `cur_map[i] <= temp_mask[i] ? temp_map[i] : 0`.
- `read_only <= temp_mask`.
- `cur_select <= HOME`, `op_counter <= 0`, undo register invalidated.

PLAY accepts at most one action per cycle, in this priority:
1. Entry: `num_valid & num_ready`.
2. `CENTER`.
3. `UNDO`.
4. `UP`.
5. `DOWN`.
6. `LEFT`.
7. `RIGHT`.

Lower-priority pulses arriving in the same cycle are dropped.

Entry:
- Rejected, with `write_reject` pulsed and no other change, if `read_only[cur_select]` is set or `num_code > SIDE`.
- Otherwise: save (`cur_select`, old value) to the undo register, mark it valid, write `num_code`, and increment `op_counter`.
- `op_counter` wraps to 0 after `OPS_MAX`.
- An entry of 0 counts as an entry.

CENTER (clear):
- Locked cell: no effect and no reject pulse.
- Otherwise: save undo, write 0. `op_counter` is unchanged.

UNDO:
- If the undo register is valid: restore the saved value at the saved index (the cursor is not moved), then invalidate the register.
- If invalid: no-op.
- `op_counter` is unchanged.

Moves (toroidal wrap on the SIDE x SIDE grid):
- UP: row 0 -> row SIDE-1, else `-SIDE`.
- DOWN: row SIDE-1 -> row 0, else `+SIDE`.
- LEFT: col 0 -> col SIDE-1 (same row), else `-1`.
- RIGHT: col SIDE-1 -> col 0 (same row), else `+1`.

`num_ready` = (state==PLAY).

UNINIT and FROZEN ignore all action inputs, including moves.

## Timing
- Reset values:
  - State UNINIT.
  - `cur_map` = 0, `read_only` = 0, `cur_select` = 0.
  - `inited` = 0, `op_counter` = 0, `num_ready` = 0, `write_reject` = 0.
  - Undo register invalid.
- All outputs are registered.
- An action accepted at edge N is visible after edge N. `write_reject` is high for exactly that one cycle.
- `init_tag` rise at edge N:
  - LOAD occupies N+1.
  - Loaded grid and `inited`=1 are visible after N+1.
  - `num_ready`=1 from N+2.
- `win_tag` sampled at edge N: state is FROZEN after N. An entry presented at edge N is still processed (same-cycle priority goes to the action); `num_ready` drops after N.
- `init_tag` falling while in PLAY: moves to UNINIT next edge; `inited`, `num_ready` = 0.
- `RST_n` low overrides everything, including a LOAD in progress.
- `num_valid` held high: one entry per cycle while `num_ready`=1.

## Test plan
- BOX=3. Reset, then `init_tag`=1 with `temp_mask[40]`=1 and `temp_map[40]`=7 -> after 2 edges `cur_map[40]`=7, other unmasked cells 0, `cur_select`=40, `inited`=1, `num_ready`=1.
- Cursor at 40, entry 5 -> `write_reject` pulses, `cur_map[40]`=7. RIGHT, then entry 5 -> `cur_map[41]`=5, `op_counter`=1. Entry 10 -> reject.
- Cursor 0: UP -> 72; LEFT from 72 -> 80; RIGHT -> 72; DOWN -> 0.
- Cell 41: write 3 over 5, then UNDO -> `cur_map[41]`=5. A second UNDO -> no change. CENTER -> 0, then UNDO -> 5.
- `op_counter` preset to 9999 via 9999 entries (or OPS_MAX=3 build) -> next entry yields 0.
- `lose_tag`=1 -> entries and moves ignored, `num_ready`=0. Release -> PLAY. `RST_n`=0 mid-game -> all outputs 0 next edge. BOX=2 build: wrap at SIDE=4 verified.
